// File: rtl/prime_scan_ctrl_if.sv
// rtl/prime_scan_ctrl_if.sv - en/valid handshake between the scan sequencer and one prime checker unit
interface prime_scan_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             pu_en_o;
    logic [WIDTH-1:0] pu_data_o;
    logic             pu_valid_i;
    logic             pu_prime_i;

    modport master (
        output pu_en_o,
        output pu_data_o,
        input  pu_valid_i,
        input  pu_prime_i
    );

    modport slave (
        input  pu_en_o,
        input  pu_data_o,
        output pu_valid_i,
        output pu_prime_i
    );
endinterface

// File: rtl/prime_scan_ctrl.sv
// rtl/prime_scan_ctrl.sv - range scanner driving one prime unit, counting and reporting primes found
// Optional WAIT timeout and sticky err_o are built only when PRIME_SCAN_TIMEOUT_EN is defined.
module prime_scan_ctrl #(
    parameter int WIDTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     lo_i,
    input  logic [WIDTH-1:0]     hi_i,
    input  logic                 abort_i,
    prime_scan_ctrl_if.master    pu,
    output logic                 hit_valid_o,
    output logic [WIDTH-1:0]     hit_data_o,
    output logic [WIDTH:0]       count_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] cur_d, hi_d, hit_data_d;
    logic [WIDTH:0]   count_d;
    logic             en_d, busy_d, done_d, hit_valid_d;
    logic             start_ok, start_any, accept, timeout;

    assign start_any = (state_q == S_IDLE) && start_i;
    assign start_ok  = start_any && (lo_i <= hi_i);
    assign accept    = (state_q == S_WAIT) && pu.pu_valid_i && !abort_i;

`ifdef PRIME_SCAN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    // Counter is zero in ISSUE, so the first WAIT cycle sees 0 and the last allowed sees TIMEOUT_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            err_o     <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == S_WAIT) ? tmo_cnt_q + CNT_W'(1) : '0;
            if (start_any)
                err_o <= 1'b0;
            else if (timeout && !abort_i)
                err_o <= 1'b1;
        end
    end

    assign timeout = (state_q == S_WAIT) && !pu.pu_valid_i &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hi_q         <= '0;
            pu.pu_en_o   <= 1'b0;
            pu.pu_data_o <= '0;
            hit_valid_o  <= 1'b0;
            hit_data_o   <= '0;
            count_o      <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            pu.pu_en_o   <= en_d;
            pu.pu_data_o <= cur_d;
            hit_valid_o  <= hit_valid_d;
            hit_data_o   <= hit_data_d;
            count_o      <= count_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = (lo_i <= hi_i) ? S_ISSUE : S_DONE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (pu.pu_valid_i)
                    state_d = (pu.pu_data_o == hi_q) ? S_DONE : S_ISSUE;
                else if (timeout)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything, including a result landing in the same cycle.
        if (abort_i && state_q != S_IDLE)
            state_d = S_IDLE;
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        en_d        = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        hit_valid_d = accept && pu.pu_prime_i;
        hit_data_d  = hit_valid_d ? pu.pu_data_o : hit_data_o;
        cur_d       = pu.pu_data_o;
        hi_d        = hi_q;
        count_d     = count_o;
        if (start_any)
            count_d = '0;
        else if (hit_valid_d)
            count_d = count_o + (WIDTH+1)'(1);
        if (start_ok) begin
            cur_d = lo_i;
            hi_d  = hi_i;
        end else if (accept && pu.pu_data_o != hi_q) begin
            cur_d = pu.pu_data_o + WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_prime_scan_ctrl.sv
// tb/tb_prime_scan_ctrl.sv - self-checking bench for prime_scan_ctrl with a behavioural prime unit
module tb_prime_scan_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] lo_i = '0;
    logic [W-1:0] hi_i = '0;
    logic         abort_i = 1'b0;
    logic         hit_valid_o;
    logic [W-1:0] hit_data_o;
    logic [W:0]   count_o;
    logic         busy_o, done_o, err_o;

    prime_scan_ctrl_if #(.WIDTH(W)) pu_if ();

    prime_scan_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .lo_i(lo_i), .hi_i(hi_i),
        .abort_i(abort_i), .pu(pu_if), .hit_valid_o(hit_valid_o), .hit_data_o(hit_data_o),
        .count_o(count_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int lat_cfg = 3;
    bit stall = 1'b0;
    int en_cnt = 0, done_cnt = 0, zero_cnt = 0;
    int hitq[$];

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural prime unit: result lat_cfg cycles after en, prime_i is noise when not valid.
    initial begin : prime_model
        bit pend;
        int m_cnt, m_data;
        pend = 1'b0; m_cnt = 0; m_data = 0;
        pu_if.pu_valid_i = 1'b0;
        pu_if.pu_prime_i = 1'b0;
        forever begin
            @(negedge clk);
            pu_if.pu_valid_i = 1'b0;
            pu_if.pu_prime_i = 1'($urandom_range(0, 1));
            if (!rst_n || !busy_o) begin
                pend = 1'b0;
            end else if (pend && !stall) begin
                if (m_cnt == 0) begin
                    pu_if.pu_valid_i = 1'b1;
                    pu_if.pu_prime_i = is_prime(m_data);
                    pend = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            if (rst_n && pu_if.pu_en_o) begin
                pend   = 1'b1;
                m_data = int'(pu_if.pu_data_o);
                m_cnt  = lat_cfg - 1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pu_if.pu_en_o) en_cnt++;
                if (done_o) done_cnt++;
                if (hit_valid_o) hitq.push_back(int'(hit_data_o));
                if (busy_o && pu_if.pu_data_o == '0) zero_cnt++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int lo, input int hi);
        start_i = 1'b1; lo_i = W'(lo); hi_i = W'(hi);
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 2000) begin
            tick();
            n++;
        end
        if (busy_o) check({tag, "_idle_timeout"}, 32'(busy_o), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int want_data);
        int n = 0;
        while (!(pu_if.pu_valid_i && (want_data < 0 || int'(pu_if.pu_data_o) == want_data)) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    // Full scan compared against a reference list built by trial division over [lo, hi].
    task automatic run_scan(input int lo, input int hi, input int lat, input string tag);
        int h0, e0, d0, z0, exp_en;
        int ref_q[$];
        h0 = hitq.size(); e0 = en_cnt; d0 = done_cnt; z0 = zero_cnt;
        for (int v = lo; v <= hi; v++)
            if (is_prime(v)) ref_q.push_back(v);
        exp_en = (lo <= hi) ? hi - lo + 1 : 0;
        lat_cfg = lat;
        pulse_start(lo, hi);
        wait_idle(tag);
        tick();
        check({tag, "_count"}, 32'(count_o), 32'(ref_q.size()));
        check({tag, "_nhits"}, 32'(hitq.size() - h0), 32'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && h0 + i < hitq.size(); i++)
            check({tag, "_hit"}, 32'(hitq[h0 + i]), 32'(ref_q[i]));
        check({tag, "_en_pulses"}, 32'(en_cnt - e0), 32'(exp_en));
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_zero_data"}, 32'(lo > 0 ? zero_cnt - z0 : 0), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    typedef struct {
        int lo;
        int hi;
        int lat;
        int exp_count;
        int exp_en;
    } vec_t;

    vec_t vecs[7];

    initial begin : main
        int d0, e0, n;
        vecs[0] = '{lo: 2,  hi: 7,  lat: 3, exp_count: 4, exp_en: 6};
        vecs[1] = '{lo: 9,  hi: 3,  lat: 3, exp_count: 0, exp_en: 0};
        vecs[2] = '{lo: 13, hi: 15, lat: 2, exp_count: 1, exp_en: 3};
        vecs[3] = '{lo: 0,  hi: 15, lat: 1, exp_count: 6, exp_en: 16};
        vecs[4] = '{lo: 0,  hi: 1,  lat: 2, exp_count: 0, exp_en: 2};
        vecs[5] = '{lo: 11, hi: 11, lat: 4, exp_count: 1, exp_en: 1};
        vecs[6] = '{lo: 4,  hi: 4,  lat: 1, exp_count: 0, exp_en: 1};

        #2 rst_n = 1'b0;
        tick(); tick();
        check("rst_en", 32'(pu_if.pu_en_o), 32'd0);
        check("rst_data", 32'(pu_if.pu_data_o), 32'd0);
        check("rst_hit_valid", 32'(hit_valid_o), 32'd0);
        check("rst_hit_data", 32'(hit_data_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            e0 = en_cnt;
            run_scan(vecs[i].lo, vecs[i].hi, vecs[i].lat, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_tbl_count", i), 32'(count_o), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_tbl_en", i), 32'(en_cnt - e0), 32'(vecs[i].exp_en));
        end

        // lo > hi: done in cycle 1, no test issued.
        pulse_start(9, 3);
        check("inv_done_c1", 32'(done_o), 32'd1);
        check("inv_en_c1", 32'(pu_if.pu_en_o), 32'd0);
        check("inv_busy_c1", 32'(busy_o), 32'd1);
        tick();
        check("inv_busy_c2", 32'(busy_o), 32'd0);
        check("inv_done_c2", 32'(done_o), 32'd0);

        // Cycle-exact hit and next issue after a result.
        lat_cfg = 2;
        pulse_start(5, 6);
        check("seq_issue_en", 32'(pu_if.pu_en_o), 32'd1);
        check("seq_issue_data", 32'(pu_if.pu_data_o), 32'd5);
        wait_valid("seq5", 5);
        tick();
        check("seq_hit_valid", 32'(hit_valid_o), 32'd1);
        check("seq_hit_data", 32'(hit_data_o), 32'd5);
        check("seq_next_en", 32'(pu_if.pu_en_o), 32'd1);
        check("seq_next_data", 32'(pu_if.pu_data_o), 32'd6);
        wait_valid("seq6", 6);
        tick();
        check("seq_done", 32'(done_o), 32'd1);
        check("seq_no_hit6", 32'(hit_valid_o), 32'd0);
        tick();
        check("seq_idle", 32'(busy_o), 32'd0);
        check("seq_count", 32'(count_o), 32'd1);

        // Abort coinciding with the result for 6; a stray start mid-scan must be ignored.
        lat_cfg = 3;
        d0 = done_cnt;
        n = hitq.size();
        pulse_start(2, 15);
        wait_valid("ab3", 3);
        pulse_start(0, 1);
        wait_valid("ab6", 6);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_en", 32'(pu_if.pu_en_o), 32'd0);
        check("abort_count", 32'(count_o), 32'd3);
        tick(); tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_nhits", 32'(hitq.size() - n), 32'd3);
        if (hitq.size() - n == 3) begin
            check("abort_hit0", 32'(hitq[n]), 32'd2);
            check("abort_hit1", 32'(hitq[n + 1]), 32'd3);
            check("abort_hit2", 32'(hitq[n + 2]), 32'd5);
        end
        check("abort_count_hold", 32'(count_o), 32'd3);

        // Asynchronous reset in the middle of a WAIT.
        lat_cfg = 4;
        pulse_start(2, 15);
        n = 0;
        while (!(pu_if.pu_data_o == W'(5) && !pu_if.pu_en_o) && n < 200) begin
            tick();
            n++;
        end
        check("rstmid_reached", 32'(n < 200), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy_o), 32'd0);
        check("rstmid_data", 32'(pu_if.pu_data_o), 32'd0);
        check("rstmid_count", 32'(count_o), 32'd0);
        check("rstmid_hit_data", 32'(hit_data_o), 32'd0);
        check("rstmid_en", 32'(pu_if.pu_en_o), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        run_scan(2, 3, 2, "post_rst");

`ifdef PRIME_SCAN_TIMEOUT_EN
        // Stalled unit: ISSUE in cycle 1, eight WAIT cycles, DONE in cycle 10.
        stall = 1'b1;
        pulse_start(4, 4);
        n = 1;
        while (!done_o && n < 50) begin
            tick();
            n++;
        end
        check("tmo_done_cycle", 32'(n), 32'd10);
        check("tmo_err", 32'(err_o), 32'd1);
        stall = 1'b0;
        tick(); tick();
        check("tmo_err_sticky", 32'(err_o), 32'd1);
        run_scan(2, 3, 2, "tmo_clear");
`endif

        for (int r = 0; r < 20; r++) begin
            run_scan(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(1, 5)), $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
